// File: rtl/com_fifo_rd_pack.sv
// com_fifo_rd_pack: pops DW-bit words from a show-ahead FIFO and packs RATIO of them into one registered OW-bit beat
module com_fifo_rd_pack #(
    parameter int DW    = 8,
    parameter int RATIO = 4,
    parameter int OW    = DW*RATIO,
    parameter int CW    = $clog2(RATIO+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_rd_data,
    input  logic          fifo_rd_empty,
    input  logic          flush,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [OW-1:0] o_data,
    output logic [CW-1:0] o_bcnt,
    output logic          busy
);
    localparam int IW = $clog2(RATIO);
    localparam int AW = (RATIO-1)*DW;

    logic [IW-1:0] idx;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_m;
    logic          flush_pend;
    logic          slot_free;
    logic          last;
    logic          emit;

    assign slot_free  = !o_valid || o_ready;
    assign last       = idx == IW'(RATIO-1);
    assign fifo_rd_en = !clear && !fifo_rd_empty && !flush_pend && !(last && !slot_free);
    assign emit       = flush_pend && idx != '0 && slot_free;
    assign busy       = idx != '0 || o_valid || flush_pend;

    // keep only the words gathered for the current beat; stale slots read as zero
    always_comb begin
        acc_m = '0;
        for (int i = 0; i < RATIO-1; i++)
            acc_m[i*DW +: DW] = (IW'(i) < idx) ? acc[i*DW +: DW] : '0;
    end

    // word accumulator, slot index and pending-flush flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            acc        <= '0;
            flush_pend <= 1'b0;
        end else if (clear) begin
            idx        <= '0;
            acc        <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (fifo_rd_en && !last) begin
                acc[idx*DW +: DW] <= fifo_rd_data;
                idx               <= idx + 1'b1;
            end else if ((fifo_rd_en && last) || emit) begin
                idx <= '0;
            end
            if (!flush_pend)
                flush_pend <= flush;
            else if (idx == '0 || slot_free)
                flush_pend <= 1'b0;
        end
    end

    // output beat register: load full or partial beat, hold under back-pressure, zero when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_bcnt  <= '0;
        end else if (clear) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_bcnt  <= '0;
        end else if (fifo_rd_en && last) begin
            o_valid <= 1'b1;
            o_data  <= {fifo_rd_data, acc};
            o_bcnt  <= CW'(RATIO);
        end else if (emit) begin
            o_valid <= 1'b1;
            o_data  <= {{DW{1'b0}}, acc_m};
            o_bcnt  <= CW'(idx);
        end else if (o_ready) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_bcnt  <= '0;
        end
    end
endmodule

// File: tb/tb_com_fifo_rd_pack.sv
// tb_com_fifo_rd_pack: directed self-checking bench for com_fifo_rd_pack with a small FIFO model
module tb_com_fifo_rd_pack;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_empty;
    logic        flush = 1'b0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [31:0] o_data;
    logic [2:0]  o_bcnt;
    logic        busy;

    logic [7:0]  mem [0:31];
    logic [4:0]  wp = '0;
    logic [4:0]  rp = '0;
    int          pops = 0;
    logic        bad_pop = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          p0;

    com_fifo_rd_pack #(.DW(8), .RATIO(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .flush(flush), .o_valid(o_valid), .o_ready(o_ready),
        .o_data(o_data), .o_bcnt(o_bcnt), .busy(busy)
    );

    always #5 clk = ~clk;

    assign fifo_rd_empty = wp == rp;
    assign fifo_rd_data  = mem[rp];

    // FIFO model pop side
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_rd_empty) bad_pop <= 1'b1;
            rp   <= rp + 1'b1;
            pops <= pops + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wp] = d;
        wp = wp + 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 20), 32'd1);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", o_data, 0);
        chk("rst_bcnt", 32'(o_bcnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);

        // T1: four words, ready high
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1 chk("t1_rd0", 32'(fifo_rd_en), 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("t1_rd", 32'(fifo_rd_en), 1);
        end
        @(negedge clk);
        chk("t1_valid", 32'(o_valid), 1);
        chk("t1_data", o_data, 32'h44332211);
        chk("t1_bcnt", 32'(o_bcnt), 4);
        chk("t1_rd_end", 32'(fifo_rd_en), 0);
        @(negedge clk);
        chk("t1_drop", 32'(o_valid), 0);
        chk("t1_zero", o_data, 0);

        // T2: back-pressure with eight words
        o_ready = 1'b0;
        p0 = pops;
        for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
        repeat (10) @(negedge clk);
        chk("t2_pops7", 32'(pops - p0), 7);
        chk("t2_hold_v", 32'(o_valid), 1);
        chk("t2_hold_d", o_data, 32'h44332211);
        chk("t2_hold_b", 32'(o_bcnt), 4);
        chk("t2_blocked", 32'(fifo_rd_en), 0);
        chk("t2_left", 32'(fifo_rd_empty), 0);
        o_ready = 1'b1;
        #1 chk("t2_rd_acc", 32'(fifo_rd_en), 1);
        @(negedge clk);
        chk("t2_v2", 32'(o_valid), 1);
        chk("t2_d2", o_data, 32'h88776655);
        chk("t2_pops8", 32'(pops - p0), 8);
        @(negedge clk);
        chk("t2_drop", 32'(o_valid), 0);

        // T3: partial beat of three words via flush
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (4) @(negedge clk);
        chk("t3_nobeat", 32'(o_valid), 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t3_pend", 32'(o_valid), 0);
        @(negedge clk);
        chk("t3_valid", 32'(o_valid), 1);
        chk("t3_data", o_data, 32'h00A3A2A1);
        chk("t3_bcnt", 32'(o_bcnt), 3);
        @(negedge clk);
        chk("t3_idle", 32'(busy), 0);

        // T4: flush with nothing accumulated
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4_busy1", 32'(busy), 1);
        chk("t4_v1", 32'(o_valid), 0);
        @(negedge clk);
        chk("t4_busy2", 32'(busy), 0);
        chk("t4_v2", 32'(o_valid), 0);

        // T5: flush coinciding with the second pop
        push(8'hB1); push(8'hB2);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        #1 chk("t5_blocked", 32'(fifo_rd_en), 0);
        @(negedge clk);
        chk("t5_valid", 32'(o_valid), 1);
        chk("t5_data", o_data, 32'h0000B2B1);
        chk("t5_bcnt", 32'(o_bcnt), 2);
        chk("t5_resume", 32'(fifo_rd_en), 1);
        repeat (4) @(negedge clk);
        chk("t5_v2", 32'(o_valid), 1);
        chk("t5_d2", o_data, 32'hC4C3C2C1);
        @(negedge clk);

        // T6: clear mid-beat, then async reset with a held beat
        push(8'hD1); push(8'hD2); push(8'h61);
        repeat (2) @(negedge clk);
        chk("t6_busy", 32'(busy), 1);
        clear = 1'b1;
        #1 chk("t6_clr_rd", 32'(fifo_rd_en), 0);
        @(negedge clk);
        clear = 1'b0;
        chk("t6_clr_busy", 32'(busy), 0);
        chk("t6_clr_v", 32'(o_valid), 0);
        o_ready = 1'b0;
        for (int i = 1; i <= 7; i++) push(8'(8'h70 + i));
        repeat (10) @(negedge clk);
        chk("t6_held", o_data, 32'h73727161);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_v", 32'(o_valid), 0);
        chk("t6_rst_d", o_data, 0);
        chk("t6_rst_b", 32'(o_bcnt), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        #1 rst_n = 1'b1;
        o_ready = 1'b1;
        push(8'h81); push(8'h82); push(8'h83);
        wait_valid("t6_timeout");
        chk("t6_fresh_d", o_data, 32'h83828177);
        chk("t6_fresh_b", 32'(o_bcnt), 4);
        chk("no_empty_pop", 32'(bad_pop), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
